// File: rtl/lsu_dmem_master.sv
//------------------------------------------------------------------------------
// lsu_dmem_master
//   Load/store initiator between the core memory stage and a single-port
//   data memory (asynchronous read, synchronous write, 32-bit words indexed
//   by addr[31:2]). One request is in flight at a time. Sub-word stores use
//   read-modify-write; loads are lane-selected and sign/zero-extended.
//
//   Build option: LSU_MISALIGN_TRAP_EN
//     defined   : misaligned H/W requests are rejected with rsp_err.
//     undefined : misaligned H/W addresses are aligned downward and executed.
//
//   Ports
//     clk, rst_n              clock, asynchronous active-low reset
//     req_valid/req_ready     request handshake (ready only while idle)
//     req_we, req_funct3      direction and RV32 size/sign code
//     req_addr, req_wdata     byte address, LSB-justified store data
//     rsp_valid/rsp_err       one-cycle response strobe and reject flag
//     rsp_rdata               extended load data (0 for stores/errors)
//     mem_we/mem_addr         memory write enable, word-aligned address
//     mem_wdata/mem_rdata     memory write data, combinational read data
//
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module lsu_dmem_master #(
  parameter int MEM_WORDS = 64,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_RSP  = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] c_mem_words = ADDR_W'(MEM_WORDS);

  state_e              state_q, state_d;
  logic                we_q;
  logic [2:0]          funct3_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         old_word_q;

  logic                w_accept;
  logic                w_f3_bad;
  logic                w_range_bad;
  logic                w_req_err;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_load_data;
  logic [31:0]         w_merged;

  assign w_accept = req_valid && (state_q == S_IDLE);

  // Request classification, evaluated on the accept cycle only.
  always_comb begin
    if (req_we) begin
      w_f3_bad = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      w_f3_bad = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end
    w_range_bad = ({2'b00, req_addr[ADDR_W-1:2]} >= c_mem_words);
`ifdef LSU_MISALIGN_TRAP_EN
    w_req_err = w_f3_bad || w_range_bad ||
                ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    // Misaligned H/W fall through: lane selection below only looks at the
    // address bits meaningful for the access size, which aligns them down.
    w_req_err = w_f3_bad || w_range_bad;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      old_word_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (w_accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (state_q == S_RD) begin
        old_word_q <= mem_rdata;
      end
    end
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    w_byte = old_word_q[7:0];
      2'd1:    w_byte = old_word_q[15:8];
      2'd2:    w_byte = old_word_q[23:16];
      default: w_byte = old_word_q[31:24];
    endcase
    w_half = addr_q[1] ? old_word_q[31:16] : old_word_q[15:0];

    case (funct3_q)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'h0, w_byte};
      3'b101:  w_load_data = {16'h0, w_half};
      default: w_load_data = old_word_q;
    endcase

    w_merged = old_word_q;
    case (funct3_q[1:0])
      2'b00: begin
        case (addr_q[1:0])
          2'd0:    w_merged[7:0]   = wdata_q[7:0];
          2'd1:    w_merged[15:8]  = wdata_q[7:0];
          2'd2:    w_merged[23:16] = wdata_q[7:0];
          default: w_merged[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) begin
          w_merged[31:16] = wdata_q[15:0];
        end else begin
          w_merged[15:0] = wdata_q[15:0];
        end
      end
      default: w_merged = wdata_q;
    endcase
  end

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = 32'h0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_err) begin
            state_d = S_ERR;
          end else if (!req_we || (req_funct3[1:0] != 2'b10)) begin
            state_d = S_RD;
          end else begin
            state_d = S_WR;
          end
        end
      end
      S_RD: begin
        mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
        state_d  = we_q ? S_WR : S_RSP;
      end
      S_WR: begin
        mem_we    = 1'b1;
        mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        mem_wdata = w_merged;
        state_d   = S_RSP;
      end
      S_RSP: begin
        rsp_valid = 1'b1;
        rsp_rdata = we_q ? 32'h0 : w_load_data;
        state_d   = S_IDLE;
      end
      S_ERR: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_dmem_master.sv
//------------------------------------------------------------------------------
// tb_lsu_dmem_master
//   Self-checking bench for lsu_dmem_master. Provides the data memory,
//   a behavioural request model and directed plus randomized scenarios.
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lsu_dmem_master;
  localparam int MEM_WORDS = 64;
  localparam int ADDR_W    = 32;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;
  int pcyc   = 0;

  logic [31:0] dmem    [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  logic        bk_we = 1'b0;
  logic [5:0]  bk_idx = 6'd0;
  logic [31:0] bk_data = 32'h0;

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          nwr;
    int          wk;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        side_bad;
    int          acc_cyc;
  } obs_t;

  lsu_dmem_master #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pcyc <= pcyc + 1;
    if (bk_we) dmem[bk_idx] <= bk_data;
    else if (mem_we && (mem_addr[31:2] < 30'(MEM_WORDS))) dmem[mem_addr[7:2]] <= mem_wdata;
  end

  assign mem_rdata = (mem_addr[31:2] < 30'(MEM_WORDS)) ? dmem[mem_addr[7:2]] : 32'h0;

  // Reference behaviour from the architectural rules: size in bytes, byte
  // offsets and arithmetic extension.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic e_err, output logic [31:0] e_rdata,
                                output int e_lat, output logic e_wr, output int e_widx,
                                output logic [31:0] e_wword);
    int size; bit legal; bit mis; logic [31:0] eff; logic [31:0] word; int off; logic [31:0] v;
    legal = we ? (f3 <= 3'd2) : ((f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5));
    size  = 1 << f3[1:0];
    mis   = (addr % 32'(size)) != 32'd0;
    e_err = !legal || ((addr >> 2) >= 32'(MEM_WORDS)) || (TRAP && mis);
    e_rdata = 32'h0; e_wr = 1'b0; e_widx = 0; e_wword = 32'h0; e_lat = 1;
    if (e_err) return;
    eff    = addr - (addr % 32'(size));
    e_widx = int'(eff >> 2);
    word   = ref_mem[e_widx];
    off    = int'(eff % 32'd4);
    if (!we) begin
      e_lat = 2;
      v = word >> (8 * off);
      if (size == 1) begin
        v = v & 32'hFF;
        if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
      end else if (size == 2) begin
        v = v & 32'hFFFF;
        if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
      end
      e_rdata = v;
    end else begin
      e_lat   = (size == 4) ? 2 : 3;
      e_wr    = 1'b1;
      e_wword = word;
      for (int b = 0; b < size; b++) e_wword[8*(off+b) +: 8] = wd[8*b +: 8];
    end
  endfunction

  task automatic poke(input int idx, input logic [31:0] data);
    bk_we = 1'b1; bk_idx = 6'(idx); bk_data = data;
    @(negedge clk);
    bk_we = 1'b0;
    ref_mem[idx] = data;
  endtask

  // Drives one request from a negedge and records what the DUT does until
  // the response; random junk is presented while the block is busy.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output obs_t o);
    int guard;
    o = '{default: 0};
    o.lat = -1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    o.acc_cyc = pcyc;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (mem_we) begin
        o.nwr++; o.wk = k; o.waddr = mem_addr; o.wdata = mem_wdata;
      end
      if (!rsp_valid && (rsp_rdata != 32'h0 || rsp_err)) o.side_bad = 1'b1;
      if (rsp_valid) begin
        o.lat = k; o.err = rsp_err; o.rdata = rsp_rdata;
        if (mem_addr != 32'h0 || mem_we) o.side_bad = 1'b1;
        break;
      end
      req_valid = 1'b1; req_we = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, mem_we} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl: got ready/valid/err/we=%b expected 1000", {req_ready, rsp_valid, rsp_err, mem_we});
    end
    checks++;
    if ({rsp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h expected all 0", rsp_rdata, mem_addr, mem_wdata);
    end
    for (int i = 0; i < MEM_WORDS; i++) poke(i, $urandom);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, mem_we, mem_addr} !== {3'b100, 32'h0}) begin
      errors++;
      $display("FAIL post_reset_idle: got ready=%b valid=%b we=%b addr=%h expected 1 0 0 0", req_ready, rsp_valid, mem_we, mem_addr);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
    logic [31:0] adrs [6] = '{32'h11, 32'h11, 32'h12, 32'h12, 32'h10, 32'h13};
    logic [31:0] exps [6] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899, 32'h8899AABB, 32'hFFFFFF88};
    obs_t o;
    poke(4, 32'h8899AABB);
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, f3s[i], adrs[i], $urandom, o);
      checks++;
      if (o.lat !== 2 || o.err !== 1'b0 || o.rdata !== exps[i] || o.nwr !== 0) begin
        errors++;
        $display("FAIL load_%0d: got lat=%0d err=%b rdata=%h writes=%0d expected lat=2 err=0 rdata=%h writes=0", i, o.lat, o.err, o.rdata, o.nwr, exps[i]);
      end
    end
  endtask

  task automatic test_sw();
    obs_t o;
    issue(1'b1, 3'b010, 32'h08, 32'hDEADBEEF, o);
    ref_mem[2] = 32'hDEADBEEF;
    checks++;
    if (o.lat !== 2 || o.err !== 1'b0 || o.rdata !== 32'h0) begin
      errors++;
      $display("FAIL sw_rsp: got lat=%0d err=%b rdata=%h expected lat=2 err=0 rdata=0", o.lat, o.err, o.rdata);
    end
    checks++;
    if (o.nwr !== 1 || o.wk !== 1 || o.waddr !== 32'h08 || o.wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_write: got n=%0d at T+%0d addr=%h data=%h expected 1 at T+1 addr=8 data=deadbeef", o.nwr, o.wk, o.waddr, o.wdata);
    end
    issue(1'b0, 3'b010, 32'h08, 32'h0, o);
    checks++;
    if (o.rdata !== 32'hDEADBEEF || o.lat !== 2) begin
      errors++;
      $display("FAIL sw_readback: got rdata=%h lat=%0d expected deadbeef lat=2", o.rdata, o.lat);
    end
  endtask

  task automatic test_subword();
    obs_t o;
    poke(2, 32'h11223344);
    issue(1'b1, 3'b000, 32'h09, 32'hFFFFFF55, o);
    checks++;
    if (o.lat !== 3 || o.nwr !== 1 || o.wk !== 2 || o.waddr !== 32'h08 || o.wdata !== 32'h11225544) begin
      errors++;
      $display("FAIL sb_merge: got lat=%0d n=%0d at T+%0d addr=%h data=%h expected lat=3 1 at T+2 addr=8 data=11225544", o.lat, o.nwr, o.wk, o.waddr, o.wdata);
    end
    issue(1'b1, 3'b001, 32'h0A, 32'h1234ABCD, o);
    checks++;
    if (o.lat !== 3 || o.wdata !== 32'hABCD5544 || o.err !== 1'b0) begin
      errors++;
      $display("FAIL sh_merge: got lat=%0d data=%h err=%b expected lat=3 data=abcd5544 err=0", o.lat, o.wdata, o.err);
    end
    checks++;
    if (dmem[2] !== 32'hABCD5544) begin
      errors++;
      $display("FAIL subword_mem: got word2=%h expected abcd5544", dmem[2]);
    end
    ref_mem[2] = 32'hABCD5544;
  endtask

  task automatic test_misalign();
    logic        we_t [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  f3_t [3] = '{3'b010, 3'b001, 3'b101};
    logic [31:0] ad_t [3] = '{32'h06, 32'h0B, 32'h1F};
    obs_t o; logic e_err, e_wr; logic [31:0] e_rd, e_ww; int e_lat, e_idx;
    for (int i = 0; i < 3; i++) begin
      model(we_t[i], f3_t[i], ad_t[i], 32'h0000C3A5, e_err, e_rd, e_lat, e_wr, e_idx, e_ww);
      issue(we_t[i], f3_t[i], ad_t[i], 32'h0000C3A5, o);
      if (e_wr) ref_mem[e_idx] = e_ww;
      checks++;
      if (o.err !== e_err || o.lat !== e_lat || o.rdata !== e_rd || o.nwr !== int'(e_wr) ||
          (e_wr && (o.wdata !== e_ww || o.waddr !== 32'(e_idx * 4)))) begin
        errors++;
        $display("FAIL misalign_%0d: got err=%b lat=%0d rdata=%h n=%0d wdata=%h expected err=%b lat=%0d rdata=%h n=%0d wdata=%h",
                 i, o.err, o.lat, o.rdata, o.nwr, o.wdata, e_err, e_lat, e_rd, int'(e_wr), e_ww);
      end
    end
  endtask

  task automatic test_errors();
    logic        we_t [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3_t [5] = '{3'b010, 3'b011, 3'b110, 3'b000, 3'b000};
    logic [31:0] ad_t [5] = '{32'h100, 32'h00, 32'h04, 32'hFFFFFFFC, 32'h100};
    obs_t o;
    for (int i = 0; i < 5; i++) begin
      issue(we_t[i], f3_t[i], ad_t[i], 32'hA5A5A5A5, o);
      checks++;
      if (o.err !== 1'b1 || o.lat !== 1 || o.nwr !== 0 || o.rdata !== 32'h0) begin
        errors++;
        $display("FAIL error_%0d: got err=%b lat=%0d writes=%0d rdata=%h expected err=1 lat=1 writes=0 rdata=0", i, o.err, o.lat, o.nwr, o.rdata);
      end
    end
    issue(1'b1, 3'b000, 32'hFF, 32'h5A, o);
    ref_mem[63][31:24] = 8'h5A;
    checks++;
    if (o.err !== 1'b0 || o.lat !== 3 || o.waddr !== 32'hFC || o.wdata !== ref_mem[63]) begin
      errors++;
      $display("FAIL last_word_sb: got err=%b lat=%0d addr=%h data=%h expected err=0 lat=3 addr=fc data=%h", o.err, o.lat, o.waddr, o.wdata, ref_mem[63]);
    end
  endtask

  task automatic test_reset_mid_sb();
    bit seen_rsp;
    poke(5, 32'hCAFEF00D);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h15; req_wdata = 32'h77;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (mem_we !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_sb_in_wr: got mem_we=%b expected 1 before reset", mem_we);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_sb_async: got mem_we=%b ready=%b expected 0 1", mem_we, req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_rsp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (rsp_valid) seen_rsp = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen_rsp || req_ready !== 1'b1 || dmem[5] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL rst_mid_sb_after: got rsp_seen=%b ready=%b word5=%h expected 0 1 cafef00d", seen_rsp, req_ready, dmem[5]);
    end
  endtask

  task automatic test_random_back_to_back();
    logic [2:0] lf [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    obs_t o; logic e_err, e_wr; logic [31:0] e_rd, e_ww; int e_lat, e_idx;
    int prev_acc, prev_lat, r, size;
    logic we; logic [2:0] f3; logic [31:0] addr, wd;
    prev_acc = 0; prev_lat = 0;
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 9));
      if (we) f3 = (r == 0) ? 3'b011 : 3'($urandom_range(0, 2));
      else    f3 = (r == 0) ? 3'b110 : lf[$urandom_range(0, 4)];
      r = int'($urandom_range(0, 9));
      if (r == 0)      addr = $urandom;
      else if (r == 1) addr = 32'h100 + 32'($urandom_range(0, 255));
      else             addr = 32'($urandom_range(0, 255));
      size = 1 << f3[1:0];
      if (r >= 5 && size <= 4) addr = addr & ~32'(size - 1);
      wd = $urandom;
      model(we, f3, addr, wd, e_err, e_rd, e_lat, e_wr, e_idx, e_ww);
      issue(we, f3, addr, wd, o);
      if (e_wr) ref_mem[e_idx] = e_ww;
      checks++;
      if (o.err !== e_err || o.lat !== e_lat || o.rdata !== e_rd || o.side_bad !== 1'b0) begin
        errors++;
        $display("FAIL rand_rsp_%0d: we=%b f3=%b addr=%h got err=%b lat=%0d rdata=%h side=%b expected err=%b lat=%0d rdata=%h side=0",
                 i, we, f3, addr, o.err, o.lat, o.rdata, o.side_bad, e_err, e_lat, e_rd);
      end
      checks++;
      if (o.nwr !== int'(e_wr) || (e_wr && (o.wk !== e_lat - 1 || o.waddr !== 32'(e_idx * 4) || o.wdata !== e_ww))) begin
        errors++;
        $display("FAIL rand_wr_%0d: got n=%0d at T+%0d addr=%h data=%h expected n=%0d at T+%0d addr=%h data=%h",
                 i, o.nwr, o.wk, o.waddr, o.wdata, int'(e_wr), e_lat - 1, e_idx * 4, e_ww);
      end
      if (i > 0) begin
        checks++;
        if (o.acc_cyc - prev_acc !== prev_lat + 1) begin
          errors++;
          $display("FAIL b2b_spacing_%0d: got %0d cycles expected %0d", i, o.acc_cyc - prev_acc, prev_lat + 1);
        end
      end
      prev_acc = o.acc_cyc; prev_lat = e_lat;
    end
  endtask

  task automatic test_final_memory();
    int bad;
    bad = 0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      if (dmem[i] !== ref_mem[i]) begin
        if (bad == 0) $display("FAIL mem_word_%0d: got %h expected %h", i, dmem[i], ref_mem[i]);
        bad++;
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL final_memory: got %0d differing words expected 0", bad);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    test_reset();
    test_loads();
    test_sw();
    test_subword();
    test_misalign();
    test_errors();
    test_reset_mid_sb();
    test_random_back_to_back();
    test_final_memory();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
